// File: rtl/logs_pkg.sv
// Shared types and default parameters for the logistic-map column sampler.
package logs_pkg;

  // Sweep controller states
  typedef enum logic [1:0] {
    S_RESTART = 2'd0,
    S_SETTLE  = 2'd1,
    S_CAPTURE = 2'd2,
    S_PRESENT = 2'd3
  } logs_state_e;

  localparam int unsigned LOGS_FRAC     = 8;
  localparam int unsigned LOGS_BIN_BITS = 4;
  localparam int unsigned LOGS_SETTLE   = 32;
  localparam int unsigned LOGS_CAPTURE  = 32;
  localparam int unsigned LOGS_NUM_COLS = 64;
  localparam int unsigned LOGS_R_START  = 3 << LOGS_FRAC;
  localparam int unsigned LOGS_R_STEP   = 4;

endpackage

// File: rtl/logs_col_bitmap.sv
// Per-column occupancy bitmap: decodes the top x bits into a bin and ORs it in.
module logs_col_bitmap
  import logs_pkg::*;
#(
  parameter int unsigned FRAC     = LOGS_FRAC,
  parameter int unsigned BIN_BITS = LOGS_BIN_BITS,
  localparam int unsigned BINS    = 1 << BIN_BITS
) (
  input  logic            clk,
  input  logic            i_clear,
  input  logic            i_set,
  input  logic [FRAC-1:0] i_x,
  output logic [BINS-1:0] o_bits
);

  logic [BIN_BITS-1:0] w_bin;
  logic [BINS-1:0]     w_onehot;
  logic [BINS-1:0]     r_bits;

  assign w_bin    = i_x[FRAC-1 -: BIN_BITS];
  assign w_onehot = BINS'(1) << w_bin;
  assign o_bits   = r_bits;

  // Low x bits below the bin index carry no information for the bitmap
  generate
    if (FRAC > BIN_BITS) begin : g_lsbs
      logic w_unused_lsbs;
      assign w_unused_lsbs = ^i_x[FRAC-BIN_BITS-1:0];
    end
  endgenerate

  // Clear wins over set; bins accumulate until the next clear
  always_ff @(posedge clk) begin
    if (i_clear) begin
      r_bits <= '0;
    end else if (i_set) begin
      r_bits <= r_bits | w_onehot;
    end
  end

endmodule

// File: rtl/logs_column_sampler.sv
// Sweep controller for the logistic-map iterator: settles, bins and presents one
// column per r value. Define LOGS_SATURATE_R_EN to clamp r at all-ones instead of
// wrapping when r + R_STEP overflows.
module logs_column_sampler
  import logs_pkg::*;
#(
  parameter int unsigned FRAC     = LOGS_FRAC,
  parameter int unsigned BIN_BITS = LOGS_BIN_BITS,
  parameter int unsigned SETTLE   = LOGS_SETTLE,
  parameter int unsigned CAPTURE  = LOGS_CAPTURE,
  parameter int unsigned NUM_COLS = LOGS_NUM_COLS,
  parameter int unsigned R_START  = 3 << FRAC,
  parameter int unsigned R_STEP   = LOGS_R_STEP,
  localparam int unsigned BINS    = 1 << BIN_BITS,
  localparam int unsigned IDX_W   = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [FRAC-1:0]  x,
  input  logic             next_ready,
  output logic [FRAC+1:0]  r,
  output logic             map_reset,
  output logic [BINS-1:0]  col_bits,
  output logic [IDX_W-1:0] col_index,
  output logic             col_valid,
  input  logic             col_ready
);

  localparam int unsigned RW      = FRAC + 2;
  localparam int unsigned CNT_MAX = (SETTLE > CAPTURE) ? SETTLE : CAPTURE;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

  logs_state_e      r_state;
  logic [RW-1:0]    r_r;
  logic [IDX_W-1:0] r_col_index;
  logic             r_col_valid;
  logic [CNT_W-1:0] r_cnt;
  logic [RW-1:0]    w_r_next;
  logic             w_bm_clear;
  logic             w_bm_set;

  assign r         = r_r;
  assign col_index = r_col_index;
  assign col_valid = r_col_valid;
  assign map_reset = (r_state == S_RESTART);

  assign w_bm_clear = reset | (r_state == S_RESTART);
  assign w_bm_set   = (r_state == S_CAPTURE) & next_ready;

`ifdef LOGS_SATURATE_R_EN
  logic [RW:0] w_r_sum;
  assign w_r_sum = {1'b0, r_r} + (RW+1)'(R_STEP);
  // Clamp to all-ones when the step carries out of the r range
  always_comb begin
    w_r_next = w_r_sum[RW-1:0];
    if (w_r_sum[RW]) begin
      w_r_next = '1;
    end
  end
`else
  // Plain modulo-2^(FRAC+2) step
  always_comb begin
    w_r_next = r_r + RW'(R_STEP);
  end
`endif

  logs_col_bitmap #(
    .FRAC     (FRAC),
    .BIN_BITS (BIN_BITS)
  ) u_bitmap (
    .clk     (clk),
    .i_clear (w_bm_clear),
    .i_set   (w_bm_set),
    .i_x     (x),
    .o_bits  (col_bits)
  );

  // Column sequencing: restart iterator, discard settling samples, capture, hand off
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_RESTART;
      r_r         <= RW'(R_START);
      r_col_index <= '0;
      r_col_valid <= 1'b0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        S_RESTART: begin
          r_cnt   <= '0;
          r_state <= S_SETTLE;
        end
        S_SETTLE: begin
          if (next_ready) begin
            if (r_cnt == CNT_W'(SETTLE - 1)) begin
              r_cnt   <= '0;
              r_state <= S_CAPTURE;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        S_CAPTURE: begin
          if (next_ready) begin
            if (r_cnt == CNT_W'(CAPTURE - 1)) begin
              r_cnt       <= '0;
              r_col_valid <= 1'b1;
              r_state     <= S_PRESENT;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        S_PRESENT: begin
          if (col_ready) begin
            r_col_valid <= 1'b0;
            r_state     <= S_RESTART;
            if (r_col_index == IDX_W'(NUM_COLS - 1)) begin
              r_col_index <= '0;
              r_r         <= RW'(R_START);
            end else begin
              r_col_index <= r_col_index + IDX_W'(1);
              r_r         <= w_r_next;
            end
          end
        end
        default: r_state <= S_RESTART;
      endcase
    end
  end

endmodule

// File: tb/tb_logs_column_sampler.sv
// Scoreboard bench for logs_column_sampler (default build or LOGS_SATURATE_R_EN).
module tb_logs_column_sampler;

  typedef struct packed {
    logic [15:0] bits;
    logic [5:0]  idx;
    logic [9:0]  r;
  } col_t;

  logic        clk = 1'b0;
  logic        reset, next_ready, col_ready;
  logic [7:0]  x;
  logic [9:0]  r;
  logic        map_reset, col_valid;
  logic [15:0] col_bits;
  logic [5:0]  col_index;

  logic        reset2;
  logic [9:0]  r2;
  logic        map_reset2, col_valid2;
  logic [15:0] col_bits2;
  logic [5:0]  col_index2;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  col_t        sb[$];
  logic [9:0]  exp_r   = 10'h300;
  logic [5:0]  exp_idx = 6'd0;

  always #5 clk = ~clk;

  logs_column_sampler u_dut (
    .clk        (clk),
    .reset      (reset),
    .x          (x),
    .next_ready (next_ready),
    .r          (r),
    .map_reset  (map_reset),
    .col_bits   (col_bits),
    .col_index  (col_index),
    .col_valid  (col_valid),
    .col_ready  (col_ready)
  );

  // Fast-sweeping instance used to reach the r overflow column
  logs_column_sampler #(
    .SETTLE  (1),
    .CAPTURE (1),
    .R_STEP  (8)
  ) u_dut_ovf (
    .clk        (clk),
    .reset      (reset2),
    .x          (8'h00),
    .next_ready (1'b1),
    .r          (r2),
    .map_reset  (map_reset2),
    .col_bits   (col_bits2),
    .col_index  (col_index2),
    .col_valid  (col_valid2),
    .col_ready  (1'b1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one column of pulses from the RESTART cycle on; push the expected column
  task automatic run_column(input bit fixed, input logic [7:0] sx, input logic [7:0] cx);
    col_t e;
    int unsigned n = 0;
    while (!map_reset && n < 1000) begin
      tick();
      n++;
    end
    check_eq("restart_seen", 32'(map_reset), 32'd1);
    next_ready = 1'b1;
    x = 8'hF0;
    tick();
    check_eq("map_reset_one_cycle", 32'(map_reset), 32'd0);
    for (int i = 0; i < 32; i++) begin
      x = fixed ? sx : 8'($urandom);
      tick();
    end
    e.bits = '0;
    for (int i = 0; i < 32; i++) begin
      x = fixed ? cx : 8'($urandom);
      e.bits = e.bits | (16'(1) << x[7:4]);
      tick();
    end
    next_ready = 1'b0;
    e.idx = exp_idx;
    e.r   = exp_r;
    sb.push_back(e);
  endtask

  // Wait for a presented column and compare it against the scoreboard head
  task automatic collect_column();
    col_t e;
    int unsigned n = 0;
    while (!col_valid && n < 200) begin
      tick();
      n++;
    end
    check_eq("col_valid_seen", 32'(col_valid), 32'd1);
    check_eq("sb_nonempty", 32'(sb.size()), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq("col_bits", 32'(col_bits), 32'(e.bits));
      check_eq("col_index", 32'(col_index), 32'(e.idx));
      check_eq("col_r", 32'(r), 32'(e.r));
    end
  endtask

  // Complete the handshake and check the restart with the next r
  task automatic accept_column();
    col_ready = 1'b1;
    tick();
    col_ready = 1'b0;
    if (exp_idx == 6'd63) begin
      exp_idx = 6'd0;
      exp_r   = 10'h300;
    end else begin
      exp_idx = exp_idx + 6'd1;
      exp_r   = exp_r + 10'd4;
    end
    check_eq("valid_drop", 32'(col_valid), 32'd0);
    check_eq("restart_after_accept", 32'(map_reset), 32'd1);
    check_eq("next_r", 32'(r), 32'(exp_r));
    check_eq("next_index", 32'(col_index), 32'(exp_idx));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned hs;
    reset = 1'b1; reset2 = 1'b1;
    next_ready = 1'b0; col_ready = 1'b0; x = 8'h00;
    repeat (3) tick();
    check_eq("rst_map_reset", 32'(map_reset), 32'd1);
    check_eq("rst_r", 32'(r), 32'h300);
    check_eq("rst_valid", 32'(col_valid), 32'd0);
    check_eq("rst_bits", 32'(col_bits), 32'd0);
    check_eq("rst_index", 32'(col_index), 32'd0);
    reset = 1'b0;

    // Column 0: settle values excluded, capture bin 8 only
    run_column(1'b1, 8'hFF, 8'h80);
    collect_column();
    check_eq("col0_bits_const", 32'(col_bits), 32'h0100);

    // Back-pressure: pulses while presenting must not touch the column
    next_ready = 1'b1;
    x = 8'h10;
    repeat (200) tick();
    check_eq("hold_bits", 32'(col_bits), 32'h0100);
    check_eq("hold_valid", 32'(col_valid), 32'd1);
    check_eq("hold_index", 32'(col_index), 32'd0);
    accept_column();
    next_ready = 1'b0;
    check_eq("col1_r_const", 32'(r), 32'h304);

    // Remaining columns with random samples, through the index wrap
    for (int c = 1; c < 64; c++) begin
      run_column(1'b0, 8'h00, 8'h00);
      collect_column();
      accept_column();
    end
    check_eq("wrap_index", 32'(col_index), 32'd0);
    check_eq("wrap_r", 32'(r), 32'h300);

    // Move off the reset values, then abort mid-capture
    run_column(1'b0, 8'h00, 8'h00);
    collect_column();
    accept_column();
    tick();
    next_ready = 1'b1;
    x = 8'hFF;
    repeat (32) tick();
    x = 8'hF0;
    repeat (10) tick();
    reset = 1'b1;
    next_ready = 1'b0;
    tick();
    check_eq("abort_map_reset", 32'(map_reset), 32'd1);
    check_eq("abort_r", 32'(r), 32'h300);
    check_eq("abort_index", 32'(col_index), 32'd0);
    check_eq("abort_valid", 32'(col_valid), 32'd0);
    check_eq("abort_bits", 32'(col_bits), 32'd0);
    reset = 1'b0;
    exp_r = 10'h300;
    exp_idx = 6'd0;
    run_column(1'b1, 8'hFF, 8'h30);
    collect_column();
    check_eq("post_abort_bits", 32'(col_bits), 32'h0008);
    accept_column();

    // r overflow at column 32 with R_STEP = 8
    reset2 = 1'b0;
    hs = 0;
    for (int n = 0; n < 1000 && hs < 32; n++) begin
      if (col_valid2) hs++;
      tick();
    end
    check_eq("ovf_index", 32'(col_index2), 32'd32);
`ifdef LOGS_SATURATE_R_EN
    check_eq("ovf_r", 32'(r2), 32'h3FF);
`else
    check_eq("ovf_r", 32'(r2), 32'h000);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
